train_scan: RTL

TRAIN_SCAN -- requirements
Module: train_scan

---
 rtl/train_scan.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/train_scan.sv
// ---------------------------------------------------------------------------
// train_scan
//
// A "train" of TRAIN_LEN lit digits moves across a DIGITS-wide multiplexed
// seven-segment display. Each lit digit shows "1". The leading digit also
// lights its decimal point. The train either bounces between the two ends
// (mode=0) or wraps around the end (mode=1). The two keys change the step
// period: key1 slows the train, key2 speeds it up.
//
// Ports
//   clk   : the only clock
//   rst   : synchronous reset, active-high
//   key1  : active-low, asynchronous; each key tick while held makes steps slower
//   key2  : active-low, asynchronous; each key tick while held makes steps faster
//   mode  : 0 = bounce, 1 = wrap
//   pause : active-high, present only when TRAIN_PAUSE_EN is defined;
//           freezes the train while scanning and key handling carry on
//   sseg  : active-low segments a..g in bits 0..6, DP in bit 7 (registered)
//   en    : active-low digit enables, exactly one low at a time (registered)
//
// Optional feature macro: TRAIN_PAUSE_EN
// ---------------------------------------------------------------------------
module train_scan #(
    parameter int DIGITS     = 6,
    parameter int TRAIN_LEN  = 2,
    parameter int SCAN_DIV   = 49000,
    parameter int KEY_DIV    = 5000000,
    parameter int STEP_INIT  = 5000000,
    parameter int STEP_MIN   = 500000,
    parameter int STEP_MAX   = 20000000,
    parameter int STEP_DELTA = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key1,
    input  logic              key2,
    input  logic              mode,
`ifdef TRAIN_PAUSE_EN
    input  logic              pause,
`endif
    output logic [7:0]        sseg,
    output logic [DIGITS-1:0] en
);

    localparam int IDX_W  = $clog2(DIGITS);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int KEY_W  = $clog2(KEY_DIV + 1);
    localparam int PER_W  = $clog2(STEP_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] TOP_POS  = IDX_W'(DIGITS - TRAIN_LEN);

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [PER_W-1:0]  step_cnt_q, step_cnt_d;
    logic [PER_W-1:0]  period_q,   period_d;
    logic [KEY_W-1:0]  key_cnt_q,  key_cnt_d;
    logic [IDX_W-1:0]  pos_q,      pos_d;
    dir_e              dir_q,      dir_d;
    logic              k1_s1_q, k1_s1_d, k1_s2_q, k1_s2_d;
    logic              k2_s1_q, k2_s1_d, k2_s2_q, k2_s2_d;
    logic [7:0]        sseg_q, sseg_d;
    logic [DIGITS-1:0] en_q,   en_d;

    logic              run;
    logic              scan_wrap;
    logic              step_fire;
    logic              key_tick;
    logic [PER_W:0]    per_up;
    logic [PER_W:0]    per_dn;
    logic [IDX_W:0]    off;
    logic              lit;
    logic              head;

`ifdef TRAIN_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        // Digit scan
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_wrap) begin
            scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);
        end

        // Step timer: compares against the registered period, so a shorter
        // period below the current count fires on the very next cycle.
        step_fire  = run && (step_cnt_q >= period_q - PER_W'(1));
        step_cnt_d = step_cnt_q;
        if (run) begin
            step_cnt_d = step_fire ? '0 : step_cnt_q + PER_W'(1);
        end

        // Train position and direction
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_fire) begin
            if (mode) begin
                pos_d = (pos_q == LAST_IDX) ? '0 : pos_q + IDX_W'(1);
                dir_d = DIR_FWD;
            end else if (pos_q > TOP_POS) begin
                // Left past the bounce range by a wrap-mode run; restart.
                pos_d = '0;
                dir_d = DIR_FWD;
            end else begin
                pos_d = (dir_q == DIR_FWD) ? pos_q + IDX_W'(1) : pos_q - IDX_W'(1);
                if (pos_d == TOP_POS) begin
                    dir_d = DIR_REV;
                end else if (pos_d == '0) begin
                    dir_d = DIR_FWD;
                end
            end
        end

        // Key synchronisers and sampling tick
        k1_s1_d   = key1;
        k1_s2_d   = k1_s1_q;
        k2_s1_d   = key2;
        k2_s2_d   = k2_s1_q;
        key_tick  = (key_cnt_q == KEY_W'(KEY_DIV - 1));
        key_cnt_d = key_tick ? '0 : key_cnt_q + KEY_W'(1);

        // Period update, one bit wider so neither direction can wrap.
        per_up   = {1'b0, period_q} + (PER_W+1)'(STEP_DELTA);
        per_dn   = {1'b0, period_q} - (PER_W+1)'(STEP_DELTA);
        period_d = period_q;
        if (key_tick && !k1_s2_q && k2_s2_q) begin
            period_d = (per_up > (PER_W+1)'(STEP_MAX)) ? PER_W'(STEP_MAX)
                                                       : per_up[PER_W-1:0];
        end else if (key_tick && k1_s2_q && !k2_s2_q) begin
            period_d = (per_dn[PER_W] || per_dn < (PER_W+1)'(STEP_MIN))
                       ? PER_W'(STEP_MIN) : per_dn[PER_W-1:0];
        end

        // Offset of the scanned digit from the train tail. In bounce mode a
        // digit before pos is never lit, so force an out-of-range offset.
        if (scan_idx_q >= pos_q) begin
            off = {1'b0, scan_idx_q} - {1'b0, pos_q};
        end else if (mode) begin
            off = {1'b0, scan_idx_q} + (IDX_W+1)'(DIGITS) - {1'b0, pos_q};
        end else begin
            off = '1;
        end
        lit  = (off < (IDX_W+1)'(TRAIN_LEN));
        head = (mode || dir_q == DIR_FWD) ? (off == (IDX_W+1)'(TRAIN_LEN - 1))
                                          : (off == '0);

        sseg_d = 8'hFF;
        if (lit) begin
            sseg_d = head ? 8'h79 : 8'hF9;
        end
        en_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << scan_idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            step_cnt_q <= '0;
            period_q   <= PER_W'(STEP_INIT);
            key_cnt_q  <= '0;
            pos_q      <= '0;
            dir_q      <= DIR_FWD;
            k1_s1_q    <= 1'b1;
            k1_s2_q    <= 1'b1;
            k2_s1_q    <= 1'b1;
            k2_s2_q    <= 1'b1;
            sseg_q     <= 8'hFF;
            en_q       <= '1;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            step_cnt_q <= step_cnt_d;
            period_q   <= period_d;
            key_cnt_q  <= key_cnt_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            k1_s1_q    <= k1_s1_d;
            k1_s2_q    <= k1_s2_d;
            k2_s1_q    <= k2_s1_d;
            k2_s2_q    <= k2_s2_d;
            sseg_q     <= sseg_d;
            en_q       <= en_d;
        end
    end

    assign sseg = sseg_q;
    assign en   = en_q;

endmodule
